// File: rtl/kp_host.sv
// Keypad/pad serial host: latch strobe, then 32 LSB-first bit slots
// clocked by KP_CLK, in either write (host drives) or read direction.
module kp_host #(
  parameter int LATCH_TICKS = 4,
  parameter int HALF_TICKS  = 4
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic        START,
  input  logic        WR_MODE,
  input  logic [31:0] TX_DATA,
  output logic [31:0] RX_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        KP_LATCH,
  output logic        KP_CLK,
  output logic        KP_RW,
  input  logic        KP_DIN,
  output logic        KP_DOUT
);

  typedef enum logic [2:0] {
    IDLE, LATCH, SHIFT_LO, SHIFT_HI, FINISH
  } state_t;

  localparam logic [7:0] LT_END = 8'(LATCH_TICKS - 1);
  localparam logic [7:0] HT_END = 8'(HALF_TICKS - 1);

  state_t      st_q, st_d;
  logic [7:0]  tick_q, tick_d;
  logic [5:0]  bit_q, bit_d;
  logic        wr_q, wr_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] rx_q, rx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        lat_q, lat_d;
  logic        kclk_q, kclk_d;
  logic        rw_q, rw_d;
  logic        dout_q, dout_d;
  logic [4:0]  nxt;

  assign nxt = bit_q[4:0] + 5'd1;

  always_comb begin
    st_d   = st_q;
    tick_d = tick_q;
    bit_d  = bit_q;
    wr_d   = wr_q;
    tx_d   = tx_q;
    sh_d   = sh_q;
    rx_d   = rx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    lat_d  = lat_q;
    kclk_d = kclk_q;
    rw_d   = rw_q;
    dout_d = dout_q;
    unique case (st_q)
      IDLE: begin
        if (START) begin
          wr_d   = WR_MODE;
          tx_d   = TX_DATA;
          sh_d   = '0;
          busy_d = 1'b1;
          rw_d   = ~WR_MODE;
          lat_d  = 1'b1;
          kclk_d = 1'b1;
          tick_d = '0;
          st_d   = LATCH;
        end
      end
      LATCH: begin
        if (tick_q == LT_END) begin
          tick_d = '0;
          bit_d  = '0;
          lat_d  = 1'b0;
          kclk_d = 1'b0;
          dout_d = wr_q & tx_q[0];
          st_d   = SHIFT_LO;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      SHIFT_LO: begin
        if (tick_q == HT_END) begin
          tick_d = '0;
          kclk_d = 1'b1;
          if (!wr_q) sh_d[bit_q[4:0]] = KP_DIN;
          st_d   = SHIFT_HI;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      SHIFT_HI: begin
        if (tick_q == HT_END) begin
          tick_d = '0;
          if (bit_q == 6'd31) begin
            bit_d  = '0;
            done_d = 1'b1;
            busy_d = 1'b0;
            rw_d   = 1'b1;
            dout_d = 1'b0;
            if (!wr_q) rx_d = sh_q;
            st_d   = FINISH;
          end else begin
            bit_d  = bit_q + 6'd1;
            kclk_d = 1'b0;
            dout_d = wr_q & tx_q[nxt];
            st_d   = SHIFT_LO;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      FINISH: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      st_q   <= IDLE;
      tick_q <= '0;
      bit_q  <= '0;
      wr_q   <= 1'b0;
      tx_q   <= '0;
      sh_q   <= '0;
      rx_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      lat_q  <= 1'b0;
      kclk_q <= 1'b1;
      rw_q   <= 1'b1;
      dout_q <= 1'b0;
    end else if (CE) begin
      st_q   <= st_d;
      tick_q <= tick_d;
      bit_q  <= bit_d;
      wr_q   <= wr_d;
      tx_q   <= tx_d;
      sh_q   <= sh_d;
      rx_q   <= rx_d;
      busy_q <= busy_d;
      done_q <= done_d;
      lat_q  <= lat_d;
      kclk_q <= kclk_d;
      rw_q   <= rw_d;
      dout_q <= dout_d;
    end
  end

  assign RX_DATA  = rx_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign KP_LATCH = lat_q;
  assign KP_CLK   = kclk_q;
  assign KP_RW    = rw_q;
  assign KP_DOUT  = dout_q;

endmodule

// File: tb/tb_kp_host.sv
// Directed bench for kp_host with a pad model and a transfer scoreboard.
module tb_kp_host;

  logic        CLK = 1'b0;
  logic        RESn = 1'b0;
  logic        CE = 1'b1;
  logic        START = 1'b0;
  logic        WR_MODE = 1'b0;
  logic [31:0] TX_DATA = '0;
  logic [31:0] RX_DATA;
  logic        BUSY, DONE, KP_LATCH, KP_CLK, KP_RW, KP_DOUT;
  logic        KP_DIN;

  kp_host dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .START(START),
    .WR_MODE(WR_MODE), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA),
    .BUSY(BUSY), .DONE(DONE), .KP_LATCH(KP_LATCH),
    .KP_CLK(KP_CLK), .KP_RW(KP_RW), .KP_DIN(KP_DIN),
    .KP_DOUT(KP_DOUT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pad model: loads its word on the latch strobe, shifts on KP_CLK rise
  logic [31:0] pad_word = '0;
  logic [31:0] pad_sh = '0;
  always @(posedge KP_LATCH) pad_sh = pad_word;
  always @(posedge KP_CLK) if (!KP_LATCH) pad_sh = pad_sh >> 1;
  assign KP_DIN = pad_sh[0];

  // CE generator: one CE tick every ce_div clocks
  int ce_div = 1;
  int ce_cnt = 0;
  always @(posedge CLK) begin
    #1;
    ce_cnt = (ce_cnt + 1) % ce_div;
    CE = (ce_cnt == ce_div - 1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] rx;
    logic [31:0] dout;
    int          ticks;
    int          period;
  } rec_t;
  rec_t q[$];

  int cyc = 0, tick_idx = 0, ndone = 0, nstart = 0;
  int inflight = 0, t_cnt = 0, c0 = 0, lat = 0, low = 0, pulses = 0;
  int done_idx = -100, gap = -1;
  logic [31:0] dw = '0;
  logic dirbad = 1'b0, prev_kclk = 1'b1, prev_lat = 1'b0;

  always @(negedge CLK) begin
    cyc++;
    if (!RESn) begin
      inflight = 0;
      prev_kclk = 1'b1;
      prev_lat = 1'b0;
    end else if (CE) begin
      tick_idx++;
      if (START && !BUSY && !DONE && inflight == 0) begin
        inflight = 1; t_cnt = 0; c0 = cyc;
        lat = 0; low = 0; pulses = 0; dw = '0; dirbad = 1'b0;
        nstart++;
      end
      if (inflight != 0) begin
        t_cnt++;
        if (KP_LATCH) lat++;
        if (!KP_CLK) begin
          low++;
          if (prev_kclk && pulses < 32) dw[pulses[4:0]] = KP_DOUT;
          if (prev_kclk) pulses++;
        end
        if (BUSY && q.size() > 0) begin
          if (KP_RW !== ~q[0].wr) dirbad = 1'b1;
          if (!q[0].wr && KP_DOUT !== 1'b0) dirbad = 1'b1;
        end
        if (DONE) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 32'(q.size()), 32'd1);
          end else begin
            rec_t r;
            r = q.pop_front();
            chk("ticks", 32'(t_cnt), 32'(r.ticks));
            chk("clocks", 32'(cyc - c0), 32'((r.ticks - 1) * r.period));
            chk("latch_ticks", 32'(lat), 32'd4);
            chk("clk_low_ticks", 32'(low), 32'd128);
            chk("clk_pulses", 32'(pulses), 32'd32);
            chk("dout_word", dw, r.dout);
            chk("dir_dout_ok", 32'(dirbad), 32'd0);
            chk("rx_data", RX_DATA, r.rx);
          end
          inflight = 0;
          done_idx = tick_idx;
        end
      end
      if (KP_LATCH && !prev_lat) gap = tick_idx - done_idx;
      if (DONE) ndone++;
      prev_kclk = KP_CLK;
      prev_lat = KP_LATCH;
    end
  end

  task automatic push(input logic wr, input logic [31:0] rx,
                      input logic [31:0] dout);
    rec_t r;
    r.wr = wr; r.rx = rx; r.dout = dout;
    r.ticks = 262; r.period = ce_div;
    q.push_back(r);
  endtask

  task automatic pulse_start(input logic wr, input logic [31:0] d);
    int lim;
    WR_MODE = wr; TX_DATA = d; START = 1'b1;
    lim = 0;
    do begin @(negedge CLK); lim++; end while (!CE && lim < 20);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int n, input int lim);
    int c;
    c = 0;
    while (ndone < n && c < lim) begin @(posedge CLK); c++; end
    chk("done_wait", 32'(ndone), 32'(n));
    repeat (2) @(posedge CLK);
    #1;
  endtask

  int d0, c;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_latch", 32'(KP_LATCH), 32'd0);
    chk("rst_kclk", 32'(KP_CLK), 32'd1);
    chk("rst_rw", 32'(KP_RW), 32'd1);
    chk("rst_dout", 32'(KP_DOUT), 32'd0);
    chk("rst_rx", RX_DATA, 32'h0);
    RESn = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // read with CE every clock
    pad_word = 32'hA5C3_0F81;
    push(1'b0, 32'hA5C3_0F81, 32'h0);
    pulse_start(1'b0, 32'hFFFF_FFFF);
    wait_done(1, 400);

    // write of a single set bit; RX must not move
    push(1'b1, 32'hA5C3_0F81, 32'h0000_0001);
    pulse_start(1'b1, 32'h0000_0001);
    wait_done(2, 400);

    // read with CE every third clock
    ce_div = 3;
    repeat (4) @(posedge CLK);
    #1;
    pad_word = 32'h1234_5678;
    push(1'b0, 32'h1234_5678, 32'h0);
    pulse_start(1'b0, 32'h0);
    wait_done(3, 1200);
    ce_div = 1;
    repeat (4) @(posedge CLK);
    #1;

    // second START mid-transfer is ignored
    push(1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
    pulse_start(1'b1, 32'hDEAD_BEEF);
    c = 0;
    while (pulses < 11 && c < 400) begin @(posedge CLK); c++; end
    #1;
    pulse_start(1'b0, 32'h5555_AAAA);
    wait_done(4, 400);
    d0 = nstart;
    repeat (20) @(posedge CLK);
    #1;
    chk("ignored_busy", 32'(BUSY), 32'd0);
    chk("ignored_nstart", 32'(nstart), 32'(d0));
    chk("ignored_ndone", 32'(ndone), 32'd4);

    // START held: back-to-back reads with one IDLE tick between
    pad_word = 32'h3C3C_A55A;
    push(1'b0, 32'h3C3C_A55A, 32'h0);
    push(1'b0, 32'h3C3C_A55A, 32'h0);
    WR_MODE = 1'b0; START = 1'b1;
    wait_done(5, 400);
    c = 0;
    while (!(BUSY && KP_LATCH) && c < 20) begin @(posedge CLK); c++; end
    #1;
    START = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd2);
    wait_done(6, 400);

    // reset during SHIFT_HI of bit 17
    pad_word = 32'hFFFF_FFFF;
    push(1'b0, 32'hFFFF_FFFF, 32'h0);
    pulse_start(1'b0, 32'h0);
    c = 0;
    while (!(pulses == 18 && KP_CLK) && c < 400) begin
      @(posedge CLK); #1; c++;
    end
    chk("reach_bit17_hi", 32'(pulses), 32'd18);
    #2;
    RESn = 1'b0;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_latch", 32'(KP_LATCH), 32'd0);
    chk("abort_kclk", 32'(KP_CLK), 32'd1);
    chk("abort_rw", 32'(KP_RW), 32'd1);
    chk("abort_rx", RX_DATA, 32'h0);
    q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RESn = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    chk("abort_ndone", 32'(ndone), 32'd6);
    chk("abort_idle", 32'(BUSY), 32'd0);
    chk("abort_rx_kept", RX_DATA, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kp_host.md
KP_HOST -- requirements
Module: kp_host

Interface
REQ-001 Parameter LATCH_TICKS, default 4: CE ticks KP_LATCH is held high per transfer (range 1..255).
REQ-002 Parameter HALF_TICKS, default 4: CE ticks per KP_CLK half-period (range 1..255).
REQ-003 CLK  in  1  single core clock; all state changes on its rising edge.
REQ-004 RESn  in  1  reset; the clock is one clock; reset is asynchronous and active-low.
REQ-005 CE  in  1  clock enable; the block advances only on CLK edges with CE=1.
REQ-006 START  in  1  transfer request; sampled on CE edges.
REQ-007 WR_MODE  in  1  1 = host writes TX_DATA to the pad; 0 = host reads from the pad; sampled with START.
REQ-008 TX_DATA  in  32  write payload; sampled with START.
REQ-009 RX_DATA  out  32  last completed read word.
REQ-010 BUSY  out  1  transfer in progress.
REQ-011 DONE  out  1  one CE-tick completion pulse.
REQ-012 KP_LATCH  out  1  pad latch strobe, active high.
REQ-013 KP_CLK  out  1  serial clock; idles high.
REQ-014 KP_RW  out  1  direction: 1 = pad drives KP_DIN (read); 0 = host drives KP_DOUT (write).
REQ-015 KP_DIN  in  1  serial data from the pad.
REQ-016 KP_DOUT  out  1  serial data to the pad.

Function
REQ-017 States SHALL be IDLE, LATCH, SHIFT_LO, SHIFT_HI, FINISH; the state register, tick counter (8 bit) and bit counter (6 bit) SHALL hold when CE=0.
REQ-018 IDLE: on a CE edge with START=1, the block SHALL capture WR_MODE and TX_DATA, set BUSY=1, set KP_RW=~WR_MODE, enter LATCH.
REQ-019 START while BUSY=1 SHALL be ignored, with no effect on the transfer in progress or the captured data.
REQ-020 LATCH: KP_LATCH=1, KP_CLK=1 for exactly LATCH_TICKS CE ticks, then KP_LATCH=0 and enter SHIFT_LO with bit counter 0.
REQ-021 SHIFT_LO: KP_CLK=0 for HALF_TICKS CE ticks; in write mode KP_DOUT SHALL present TX bit[bit counter] (LSB first) from the first tick of SHIFT_LO.
REQ-022 On the SHIFT_LO to SHIFT_HI transition edge, in read mode, KP_DIN SHALL be shifted into an internal receive register at bit position [bit counter].
REQ-023 SHIFT_HI: KP_CLK=1 for HALF_TICKS CE ticks; KP_DOUT SHALL hold its value; on exit, bit counter=31 enters FINISH, otherwise increment and enter SHIFT_LO.
REQ-024 FINISH, one CE tick: DONE=1, BUSY=0, KP_RW returns to 1, KP_DOUT=0; in read mode RX_DATA SHALL load the receive register on this edge; the next state is IDLE.
REQ-025 In write mode RX_DATA SHALL remain unchanged.
REQ-026 A START in the FINISH tick SHALL be ignored; a START is accepted on the first IDLE tick following FINISH.
REQ-027 The transfer SHALL take exactly 1 + LATCH_TICKS + 64*HALF_TICKS + 1 CE ticks, from the START-sampling edge through the DONE tick.
REQ-028 In read mode KP_DOUT SHALL be 0 for the whole transfer.
REQ-029 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-030 On RESn=0, the block SHALL go immediately to IDLE and set: BUSY=0, DONE=0, KP_LATCH=0, KP_CLK=1, KP_RW=1, KP_DOUT=0, RX_DATA=0, all counters 0.
REQ-031 Reset mid-transfer SHALL abort the transfer without asserting DONE; the partial receive data SHALL be discarded.

Verification
REQ-032 Read, CE=1, defaults, pad model returning 0xA5C3_0F81 LSB first -> KP_LATCH high for 4 cycles, then 32 KP_CLK low/high pulses of 4+4 cycles, DONE at cycle 262, RX_DATA=0xA5C30F81.
REQ-033 Write, TX_DATA=0x0000_0001 -> KP_RW=0, KP_DOUT=1 during bit 0 only and 0 for bits 1..31, RX_DATA unchanged, a single DONE pulse.
REQ-034 CE asserted every 3rd clock -> identical KP_* waveform measured in CE ticks, and the duration in clocks is 3x.
REQ-035 START pulsed again at bit 10 with different TX_DATA -> the first transfer completes unchanged and no second transfer starts.
REQ-036 RESn low during SHIFT_HI of bit 17 -> reset values immediately, no DONE, previous RX_DATA cleared to 0.
REQ-037 START held high continuously -> back-to-back transfers, with one IDLE tick between DONE and the next LATCH.
